// File: rtl/place_piece.sv
// Board-RAM writer: scans a tetromino's 4x4 bounding box and writes (or erases)
// its four cells into the 10x24 board RAM, clipping cells that fall off the board.
module place_piece #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] piece_type,
  input  logic [1:0] rotation,
  input  logic [3:0] piece_x,
  input  logic [4:0] piece_y,
  input  logic [5:0] colour,
  input  logic       erase,
  output logic [7:0] ram_addr,
  output logic [5:0] ram_data,
  output logic       ram_wren,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  typedef struct packed {
    logic [3:0]  x;
    logic [4:0]  y;
    logic [5:0]  data;
    logic [15:0] mask;
  } piece_t;

  state_t     state;
  piece_t     pc;
  logic [3:0] k;

  function automatic logic [15:0] base_mask(input logic [2:0] t);
    case (t)
      3'd0:    base_mask = 16'h00F0;
      3'd1:    base_mask = 16'h0066;
      3'd2:    base_mask = 16'h0072;
      3'd3:    base_mask = 16'h0036;
      3'd4:    base_mask = 16'h0063;
      3'd5:    base_mask = 16'h0071;
      3'd6:    base_mask = 16'h0074;
      default: base_mask = 16'h0000;
    endcase
  endfunction

  // One clockwise quarter turn: (dx,dy) -> (3-dy, dx).
  function automatic logic [15:0] rot_cw(input logic [15:0] m);
    rot_cw = '0;
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++)
        rot_cw[dx*4 + (3-dy)] = m[dy*4 + dx];
  endfunction

  function automatic logic [15:0] rotate(input logic [15:0] m, input logic [1:0] r);
    rotate = m;
    for (int i = 0; i < 3; i++)
      if (i < int'(r)) rotate = rot_cw(rotate);
  endfunction

  // Board coordinates carry one extra bit so x+3 / y+3 never wrap.
  logic [4:0] bx;
  logic [5:0] by;
  logic [7:0] addr_calc;
  logic       hit;

  always_comb begin
    bx        = {1'b0, pc.x} + {3'b0, k[1:0]};
    by        = {1'b0, pc.y} + {4'b0, k[3:2]};
    hit       = pc.mask[k] && (bx < 5'(BOARD_W)) && (by < 6'(BOARD_H));
    addr_calc = 8'(by) * 8'(BOARD_W) + 8'(bx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      k        <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done     <= 1'b0;
          ram_wren <= 1'b0;
          if (start) begin
            pc.x    <= piece_x;
            pc.y    <= piece_y;
            pc.data <= erase ? 6'd0 : colour;
            pc.mask <= rotate(base_mask(piece_type), rotation);
            k       <= '0;
            busy    <= 1'b1;
            state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Address/data only move on a real write so they always hold a legal value.
          ram_wren <= hit;
          if (hit) begin
            ram_addr <= addr_calc;
            ram_data <= pc.data;
          end
          k <= k + 4'd1;
          if (k == 4'd15) state <= S_DONE;
        end
        S_DONE: begin
          ram_wren <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/place_piece.md
# place_piece

Board-RAM writer for the tetromino game. Takes a piece description (shape, rotation, board position, colour) and writes its four cells into the 10×24 board RAM, or writes zeros over them when erasing. The board renderer reads the same RAM, so this block is the write side of that interface. A start/busy/done handshake drives it from the game controller, and it owns the RAM write port while busy.

## Interface
Parameters:
- BOARD_W, 10, board width in cells
- BOARD_H, 24, board height in cells. Rows 0–3 are the invisible spawn rows.

Ports:
- clk  input  1  system clock; all logic is on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a write; sampled only in IDLE
- piece_type  input  3  0=I, 1=O, 2=T, 3=S, 4=Z, 5=J, 6=L, 7=none (no writes)
- rotation  input  2  number of clockwise quarter turns, 0–3
- piece_x  input  4  board x of the 4×4 bounding box origin
- piece_y  input  5  board y of the 4×4 bounding box origin
- colour  input  6  RRGGBB colour to write
- erase  input  1  1 = write 6'b000000 instead of colour
- ram_addr  output  8  board RAM address = y*BOARD_W + x
- ram_data  output  6  board RAM write data
- ram_wren  output  1  board RAM write enable
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when the write sequence is complete

## Operation
- Shape masks are 16-bit, with bit index = dy*4 + dx inside the 4×4 box. Rotation-0 masks:
  - I 0x00F0, O 0x0066, T 0x0072, S 0x0036, Z 0x0063, J 0x0071, L 0x0074, none 0x0000.
- Rotation: each clockwise quarter turn maps cell (dx,dy) to (3−dy, dx). Rotation r applies this r times. The rotated mask is computed inside the block.
- State machine: IDLE → SCAN → DONE → IDLE.
  - IDLE: busy=0. When start=1, latch all piece inputs, clear the scan counter, go to SCAN.
  - SCAN: 4-bit counter k steps 0..15, one per cycle, with sx=k[1:0] and sy=k[3:2]. Board coordinate is bx=piece_x+sx, by=piece_y+sy, computed at 5/6-bit width so there is no wrap. After k=15, go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- Write rule for each scan position:
  - ram_wren=1 iff the rotated mask bit is set AND bx<BOARD_W AND by<BOARD_H.
  - Out-of-board cells are silently skipped, with no address wrap.
- ram_data = erase ? 0 : latched colour. ram_addr = by*BOARD_W + bx.
  - Don't-care when ram_wren=0, but it must hold a stable legal value (<240).
- Inputs changing while busy have no effect, because the latched copies are used.
- start while busy or in DONE is ignored. It is not queued.

## Timing
- Reset values: state=IDLE, busy=0, done=0, ram_wren=0, ram_addr=0, ram_data=0.
- All outputs are registered.
- If start is high at edge E0, busy=1 from E0 onward. Scan position k appears on ram_addr/ram_data/ram_wren in the cycle after edge E0+k+1, for k=0..15.
- done=1 and busy=0 in the cycle after edge E0+17.
  - Fixed latency: 17 cycles from the start edge to done, independent of shape.
- ram_wren is never high outside the 16 SCAN output cycles.
- A new start is accepted in the cycle right after done, so back-to-back pieces take 18 cycles each.
- Reset asserted mid-SCAN: the next edge forces IDLE with ram_wren=0. No further writes occur and no done pulse is produced.
- start and reset high together: reset wins.

## Test plan
- O, rot 0, x=4, y=0, colour 0x3F, erase=0 → exactly 4 writes, to addresses 5, 6, 15, 16, data 0x3F. done comes 17 cycles after start.
- I, rot 1, x=0, y=20, colour 0x30 → writes to 202, 212, 222, 232, in that order. No other wren.
- I, rot 0, x=8, y=4 (clipped on the right) → only 58 and 59 are written. No writes to wrapped addresses 60/61.
- T, rot 0, x=3, y=6, erase=1 → writes 0x00 to 64, 73, 74, 75. Colour input is ignored.
- Pulse start again at cycle 5 of a busy sequence, and change piece_x mid-scan → the original 4 addresses are unaffected, only one done pulse occurs, and no second sequence starts.
- Assert reset at scan cycle 8 of a Z write → ram_wren=0 from the next cycle, busy=0, no done. A following clean start runs a full 17-cycle sequence.
